// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_W    = 3'd1;
  localparam logic [2:0] LD_H    = 3'd2;
  localparam logic [2:0] LD_HU   = 3'd3;
  localparam logic [2:0] LD_B    = 3'd4;
  localparam logic [2:0] LD_BU   = 3'd5;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_DATA = 1'b1
  } state_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Big-endian load alignment and sign/zero extension of a raw cache word.
module load_align
  import wb_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  ldtype,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    case (addr_lo)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
  end

  always_comb begin
    case (ldtype)
      LD_H:    data = {{16{half[15]}}, half};
      LD_HU:   data = {16'h0000, half};
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'h000000, byte_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts memory-stage results, waits on late loads, drives the regfile write port.
// Optional performance counters are built when WB_PERF_EN is defined.
module wb_stage
  import wb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m_valid,
  output logic          m_ready,
  input  logic          m_regwrite,
  input  logic [AW-1:0] m_dest,
  input  logic [DW-1:0] m_alu_result,
  input  logic [2:0]    m_ldtype,
  input  logic [1:0]    m_addr_lo,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_rdata_valid,
  output logic          we3,
  output logic [AW-1:0] a3,
  output logic [DW-1:0] wd3,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_dest,
  output logic [DW-1:0] fwd_data,
  output logic          ld_stall
`ifdef WB_PERF_EN
  ,
  output logic [31:0]   perf_retired,
  output logic [31:0]   perf_ldwait
`endif
);

  state_t state, state_nxt;

  logic          w_valid, w_valid_nxt;
  logic          w_regwrite, w_regwrite_nxt;
  logic [AW-1:0] w_dest, w_dest_nxt;
  logic [DW-1:0] w_data, w_data_nxt;

  logic          c_regwrite, c_regwrite_nxt;
  logic [AW-1:0] c_dest, c_dest_nxt;
  logic [2:0]    c_ldtype, c_ldtype_nxt;
  logic [1:0]    c_addr_lo, c_addr_lo_nxt;

  logic          xfer;
  logic          is_load;
  logic [2:0]    al_ldtype;
  logic [1:0]    al_addr_lo;
  logic [31:0]   al_data;

  assign m_ready  = (state == IDLE);
  assign ld_stall = (state == WAIT_DATA);
  assign xfer     = m_valid & m_ready;
  assign is_load  = (m_ldtype != LD_NONE);

  // While waiting, alignment must use the fields captured at accept time.
  assign al_ldtype  = ld_stall ? c_ldtype  : m_ldtype;
  assign al_addr_lo = ld_stall ? c_addr_lo : m_addr_lo;

  load_align u_align (
    .rdata   (m_rdata),
    .ldtype  (al_ldtype),
    .addr_lo (al_addr_lo),
    .data    (al_data)
  );

  always_comb begin
    state_nxt      = state;
    w_valid_nxt    = 1'b0;
    w_regwrite_nxt = w_regwrite;
    w_dest_nxt     = w_dest;
    w_data_nxt     = w_data;
    c_regwrite_nxt = c_regwrite;
    c_dest_nxt     = c_dest;
    c_ldtype_nxt   = c_ldtype;
    c_addr_lo_nxt  = c_addr_lo;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (!is_load) begin
            w_valid_nxt    = 1'b1;
            w_regwrite_nxt = m_regwrite;
            w_dest_nxt     = m_dest;
            w_data_nxt     = m_alu_result;
          end else if (m_rdata_valid) begin
            w_valid_nxt    = 1'b1;
            w_regwrite_nxt = m_regwrite;
            w_dest_nxt     = m_dest;
            w_data_nxt     = al_data;
          end else begin
            c_regwrite_nxt = m_regwrite;
            c_dest_nxt     = m_dest;
            c_ldtype_nxt   = m_ldtype;
            c_addr_lo_nxt  = m_addr_lo;
            state_nxt      = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (m_rdata_valid) begin
          w_valid_nxt    = 1'b1;
          w_regwrite_nxt = c_regwrite;
          w_dest_nxt     = c_dest;
          w_data_nxt     = al_data;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      w_valid    <= 1'b0;
      w_regwrite <= 1'b0;
      w_dest     <= '0;
      w_data     <= '0;
      c_regwrite <= 1'b0;
      c_dest     <= '0;
      c_ldtype   <= LD_NONE;
      c_addr_lo  <= 2'd0;
    end else begin
      state      <= state_nxt;
      w_valid    <= w_valid_nxt;
      w_regwrite <= w_regwrite_nxt;
      w_dest     <= w_dest_nxt;
      w_data     <= w_data_nxt;
      c_regwrite <= c_regwrite_nxt;
      c_dest     <= c_dest_nxt;
      c_ldtype   <= c_ldtype_nxt;
      c_addr_lo  <= c_addr_lo_nxt;
    end
  end

  assign we3       = w_valid & w_regwrite & (w_dest != '0);
  assign a3        = w_dest;
  assign wd3       = w_data;
  assign fwd_valid = we3;
  assign fwd_dest  = w_dest;
  assign fwd_data  = w_data;

`ifdef WB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_retired <= 32'd0;
      perf_ldwait  <= 32'd0;
    end else begin
      if (we3)      perf_retired <= perf_retired + 32'd1;
      if (ld_stall) perf_ldwait  <= perf_ldwait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic        m_ready;
  logic        m_regwrite;
  logic [4:0]  m_dest;
  logic [31:0] m_alu_result;
  logic [2:0]  m_ldtype;
  logic [1:0]  m_addr_lo;
  logic [31:0] m_rdata;
  logic        m_rdata_valid;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic        ld_stall;
`ifdef WB_PERF_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_ldwait;
  logic [31:0] base_retired;
  logic [31:0] base_ldwait;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk           (clk),
    .rst           (rst),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_regwrite    (m_regwrite),
    .m_dest        (m_dest),
    .m_alu_result  (m_alu_result),
    .m_ldtype      (m_ldtype),
    .m_addr_lo     (m_addr_lo),
    .m_rdata       (m_rdata),
    .m_rdata_valid (m_rdata_valid),
    .we3           (we3),
    .a3            (a3),
    .wd3           (wd3),
    .fwd_valid     (fwd_valid),
    .fwd_dest      (fwd_dest),
    .fwd_data      (fwd_data),
    .ld_stall      (ld_stall)
`ifdef WB_PERF_EN
    ,
    .perf_retired  (perf_retired),
    .perf_ldwait   (perf_ldwait)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  lt;
    logic [1:0]  lo;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t ld_tab[6];

  initial begin
    ld_tab[0] = '{LD_B,  2'd0, 32'hFFFFFF80};
    ld_tab[1] = '{LD_BU, 2'd1, 32'h000000FF};
    ld_tab[2] = '{LD_H,  2'd2, 32'h00007F01};
    ld_tab[3] = '{LD_HU, 2'd0, 32'h000080FF};
    ld_tab[4] = '{LD_B,  2'd3, 32'h00000001};
    ld_tab[5] = '{3'd6,  2'd2, 32'h80FF7F01};

    rst = 1'b0;
    m_valid = 1'b0; m_regwrite = 1'b0; m_dest = '0; m_alu_result = '0;
    m_ldtype = LD_NONE; m_addr_lo = '0; m_rdata = '0; m_rdata_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_we3", {31'd0, we3}, 32'd0);
    chk("rst_a3", {27'd0, a3}, 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("rst_ld_stall", {31'd0, ld_stall}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_m_ready", {31'd0, m_ready}, 32'd1);

    // ALU writeback
    m_valid = 1'b1; m_regwrite = 1'b1; m_dest = 5'd8; m_alu_result = 32'hDEADBEEF;
    step();
    m_valid = 1'b0;
    chk("alu_we3", {31'd0, we3}, 32'd1);
    chk("alu_a3", {27'd0, a3}, 32'd8);
    chk("alu_wd3", wd3, 32'hDEADBEEF);
    chk("alu_fwd", {fwd_valid, 26'd0, fwd_dest}, {1'b1, 26'd0, 5'd8});
    chk("alu_fwd_data", fwd_data, 32'hDEADBEEF);
    step();
    chk("alu_we3_drop", {31'd0, we3}, 32'd0);

    // r0 suppressed at the port but latch updates
    m_valid = 1'b1; m_dest = 5'd0; m_alu_result = 32'hFFFFFFFF;
    step();
    m_valid = 1'b0;
    chk("r0_we3", {31'd0, we3}, 32'd0);
    chk("r0_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("r0_wd3", wd3, 32'hFFFFFFFF);

    // regwrite=0 retires without a write
    m_valid = 1'b1; m_regwrite = 1'b0; m_dest = 5'd9; m_alu_result = 32'h11112222;
    step();
    m_valid = 1'b0; m_regwrite = 1'b1;
    chk("norw_we3", {31'd0, we3}, 32'd0);
    chk("norw_a3", {27'd0, a3}, 32'd9);

    // Loads hitting in the same cycle
    m_rdata = 32'h80FF7F01; m_rdata_valid = 1'b1; m_dest = 5'd5;
    for (int i = 0; i < 6; i++) begin
      m_valid = 1'b1; m_ldtype = ld_tab[i].lt; m_addr_lo = ld_tab[i].lo;
      step();
      m_valid = 1'b0;
      chk($sformatf("ld%0d_wd3", i), wd3, ld_tab[i].exp);
      chk($sformatf("ld%0d_we3", i), {31'd0, we3}, 32'd1);
    end

    // Stray rdata_valid in IDLE without a transfer
    m_ldtype = LD_W; m_rdata = 32'h55555555;
    step();
    chk("stray_we3", {31'd0, we3}, 32'd0);
    chk("stray_ready", {31'd0, m_ready}, 32'd1);

    // Miss: three stall cycles, then data returns
    m_rdata_valid = 1'b0;
    m_valid = 1'b1; m_ldtype = LD_W; m_addr_lo = 2'd0; m_dest = 5'd10;
    step();
`ifdef WB_PERF_EN
    base_retired = perf_retired;
    base_ldwait  = perf_ldwait;
`endif
    // m_valid held with a different op must be ignored while stalled
    m_ldtype = LD_NONE; m_dest = 5'd11; m_alu_result = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("miss%0d_ready", i), {31'd0, m_ready}, 32'd0);
      chk($sformatf("miss%0d_stall", i), {31'd0, ld_stall}, 32'd1);
      chk($sformatf("miss%0d_we3", i), {31'd0, we3}, 32'd0);
      if (i < 2) step();
    end
    m_valid = 1'b0; m_rdata_valid = 1'b1; m_rdata = 32'h12345678;
    step();
    m_rdata_valid = 1'b0;
    chk("miss_we3", {31'd0, we3}, 32'd1);
    chk("miss_a3", {27'd0, a3}, 32'd10);
    chk("miss_wd3", wd3, 32'h12345678);
    chk("miss_ready", {31'd0, m_ready}, 32'd1);
    chk("miss_stall", {31'd0, ld_stall}, 32'd0);
    step();
    chk("miss_we3_drop", {31'd0, we3}, 32'd0);
`ifdef WB_PERF_EN
    chk("perf_ldwait", perf_ldwait - base_ldwait, 32'd3);
    chk("perf_retired", perf_retired - base_retired, 32'd1);
`endif

    // Miss with captured byte alignment
    m_valid = 1'b1; m_ldtype = LD_BU; m_addr_lo = 2'd2; m_dest = 5'd3;
    step();
    m_valid = 1'b0; m_ldtype = LD_W; m_addr_lo = 2'd0;
    m_rdata_valid = 1'b1; m_rdata = 32'hA1B2C3D4;
    step();
    m_rdata_valid = 1'b0;
    chk("miss_bu_wd3", wd3, 32'h000000C3);
    chk("miss_bu_a3", {27'd0, a3}, 32'd3);

    // Async reset in the middle of a miss
    m_valid = 1'b1; m_ldtype = LD_W; m_dest = 5'd12;
    step();
    m_valid = 1'b0;
    chk("rmid_pre_stall", {31'd0, ld_stall}, 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("rmid_stall", {31'd0, ld_stall}, 32'd0);
    chk("rmid_we3", {31'd0, we3}, 32'd0);
    chk("rmid_a3", {27'd0, a3}, 32'd0);
    chk("rmid_ready", {31'd0, m_ready}, 32'd1);
    step();
    rst = 1'b1;
    m_rdata_valid = 1'b1; m_rdata = 32'hCAFEF00D;
    step();
    chk("rmid_late_we3", {31'd0, we3}, 32'd0);
    step();
    m_rdata_valid = 1'b0;
    chk("rmid_late_we3b", {31'd0, we3}, 32'd0);
    chk("rmid_late_wd3", wd3, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
